// File: rtl/signal_ramper_multi_if.sv
// DDS phase stream bundle feeding the envelope ramper.
// Ports: s_axis_tdata_phase (phase word), s_axis_tvalid_phase (sample strobe).
// There is no ready signal, so the ramper never stalls the phase source.
interface signal_ramper_multi_if #(
  parameter int PHASE_IN_WIDTH = 48
);
  logic [PHASE_IN_WIDTH-1:0] s_axis_tdata_phase;
  logic                      s_axis_tvalid_phase;

  modport master (output s_axis_tdata_phase, output s_axis_tvalid_phase);
  modport slave  (input  s_axis_tdata_phase, input  s_axis_tvalid_phase);
endinterface

// File: rtl/signal_ramper_multi.sv
// Amplitude envelope (0..2**PHASE_BITS) from a DDS phase stream; ramp up and down
// each span 2**k phase periods, every segment starting on a phase wrap.
// Latency: phase valid in cycle t -> phase register t+1 -> ramp/state/done in t+2.
// Backpressure: none; samples with tvalid=0 leave every datapath register unchanged.
// Ports:
//   clk, aresetn            clock, async active-low reset
//   phase_if (slave)        s_axis_tdata_phase / s_axis_tvalid_phase
//   enableRamping           0 forces ramp to FULL_SCALE (FSM keeps running)
//   rampUpLog2/rampDownLog2 segment lengths as log2 periods, clamped to MAX_LOG2
//   startRampDown           sticky ramp-down request; restartRamp re-arms from DONE
//   ramp, rampState, rampDone  registered outputs, mutually aligned
module signal_ramper_multi #(
  parameter int PHASE_IN_WIDTH = 48,
  parameter int PHASE_BITS     = 13,
  parameter int OUT_WIDTH      = 16,
  parameter int LOG2_WIDTH     = 3,
  parameter int MAX_LOG2       = 4
) (
  input  logic                  clk,
  input  logic                  aresetn,
  signal_ramper_multi_if.slave  phase_if,
  input  logic                  enableRamping,
  input  logic [LOG2_WIDTH-1:0] rampUpLog2,
  input  logic [LOG2_WIDTH-1:0] rampDownLog2,
  input  logic                  startRampDown,
  input  logic                  restartRamp,
  output logic [OUT_WIDTH-1:0]  ramp,
  output logic [2:0]            rampState,
  output logic                  rampDone
);

  typedef enum logic [2:0] {
    ST_NORMAL = 3'b000,
    ST_DONE   = 3'b001,
    ST_UP     = 3'b010,
    ST_DOWN   = 3'b011,
    ST_WAIT   = 3'b100
  } state_t;

  localparam int                    PAD        = OUT_WIDTH - PHASE_BITS;
  localparam logic [OUT_WIDTH-1:0]  FULL_SCALE = OUT_WIDTH'(1) << PHASE_BITS;
  localparam logic [LOG2_WIDTH-1:0] K_MAX      = LOG2_WIDTH'(MAX_LOG2);

  function automatic logic [LOG2_WIDTH-1:0] clamp_k(input logic [LOG2_WIDTH-1:0] k);
    return (k > K_MAX) ? K_MAX : k;
  endfunction

  // Count value of the final period of a 2**k-period segment (2**k - 1).
  function automatic logic [MAX_LOG2-1:0] last_cnt(input logic [LOG2_WIDTH-1:0] k);
    logic [MAX_LOG2-1:0] r;
    for (int i = 0; i < MAX_LOG2; i++) r[i] = (i < int'(k));
    return r;
  endfunction

  // ---------------- stage 1: capture sample and its control inputs ----------------
  logic [PHASE_BITS-1:0] phase_q, phase_prev_q;
  logic                  smp_vld_q;
  logic                  en_q, start_q, restart_q;
  logic [LOG2_WIDTH-1:0] kup_in_q, kdown_in_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q      <= '0;
      phase_prev_q <= '0;
      smp_vld_q    <= 1'b0;
      en_q         <= 1'b0;
      start_q      <= 1'b0;
      restart_q    <= 1'b0;
      kup_in_q     <= '0;
      kdown_in_q   <= '0;
    end else begin
      smp_vld_q <= phase_if.s_axis_tvalid_phase;
      if (phase_if.s_axis_tvalid_phase) begin
        phase_prev_q <= phase_q;
        phase_q      <= phase_if.s_axis_tdata_phase[PHASE_IN_WIDTH-1 -: PHASE_BITS];
        en_q         <= enableRamping;
        start_q      <= startRampDown;
        restart_q    <= restartRamp;
        kup_in_q     <= rampUpLog2;
        kdown_in_q   <= rampDownLog2;
      end
    end
  end

  // ---------------- stage 2: envelope FSM ----------------
  state_t                state_q, state_d;
  logic [MAX_LOG2-1:0]   cnt_q, cnt_d;
  logic [LOG2_WIDTH-1:0] kup_q, kup_d, kdown_q, kdown_d;
  logic                  pend_q, pend_d;
  logic [OUT_WIDTH-1:0]  ramp_q, ramp_d;
  logic                  done_q;

  // phasePrev resets to 0, so the first sample can never look like a wrap.
  logic wrap, req, pend_eff;
  assign wrap     = phase_q < phase_prev_q;
  assign req      = start_q && (state_q inside {ST_WAIT, ST_UP, ST_NORMAL});
  // A request on the same sample as a segment-ending wrap is served by that wrap.
  assign pend_eff = pend_q | req;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      kup_q   <= '0;
      kdown_q <= '0;
      pend_q  <= 1'b0;
      ramp_q  <= '0;
      done_q  <= 1'b0;
    end else if (smp_vld_q) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kup_q   <= kup_d;
      kdown_q <= kdown_d;
      pend_q  <= pend_d;
      ramp_q  <= ramp_d;
      done_q  <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kup_d   = kup_q;
    kdown_d = kdown_q;
    pend_d  = (state_q == ST_DONE) ? pend_q : pend_eff;
    case (state_q)
      ST_WAIT: begin
        if (wrap) begin
          state_d = ST_UP;
          cnt_d   = '0;
          kup_d   = clamp_k(kup_in_q);
        end
      end
      ST_UP: begin
        if (wrap) begin
          if (cnt_q == last_cnt(kup_q)) begin
            if (pend_eff) begin
              state_d = ST_DOWN;
              cnt_d   = '0;
              kdown_d = clamp_k(kdown_in_q);
              pend_d  = 1'b0;
            end else begin
              state_d = ST_NORMAL;
            end
          end else begin
            cnt_d = cnt_q + MAX_LOG2'(1);
          end
        end
      end
      ST_NORMAL: begin
        if (wrap && pend_eff) begin
          state_d = ST_DOWN;
          cnt_d   = '0;
          kdown_d = clamp_k(kdown_in_q);
          pend_d  = 1'b0;
        end
      end
      ST_DOWN: begin
        if (wrap) begin
          if (cnt_q == last_cnt(kdown_q)) state_d = ST_DONE;
          else                            cnt_d   = cnt_q + MAX_LOG2'(1);
        end
      end
      ST_DONE: begin
        if (restart_q) begin
          state_d = ST_WAIT;
          pend_d  = start_q;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Ramp is computed from the already-updated state, so a segment's first sample
  // is produced by the wrap that enters it.
  logic [LOG2_WIDTH-1:0] shift_k;
  logic [PHASE_BITS-1:0] frac;

  always_comb begin
    shift_k = (state_d == ST_DOWN) ? kdown_d : kup_d;
    // cnt never exceeds 2**k-1, so the shifted position always fits PHASE_BITS.
    frac    = PHASE_BITS'({cnt_d, phase_q} >> shift_k);
    ramp_d  = '0;
    case (state_d)
      ST_UP:     ramp_d = {{PAD{1'b0}}, frac};
      // (FULL_SCALE-1) - frac is the bitwise complement within PHASE_BITS.
      ST_DOWN:   ramp_d = {{PAD{1'b0}}, ~frac};
      ST_NORMAL: ramp_d = FULL_SCALE;
      default:   ramp_d = '0;
    endcase
    if (!en_q) ramp_d = FULL_SCALE;
  end

  assign ramp      = ramp_q;
  assign rampState = state_q;
  assign rampDone  = done_q;

endmodule
